fetch_unit: RTL and testbench

// - PC/fetch stage directly upstream of the 8-bit instruction memory: drives imem_addr, captures the returned word.
// - Holds a 1-entry instruction buffer with valid/ready handshake to the decoder.
// - Resolves jumps (opcode 2'b11) locally; accepts redirects from execute; stops at end of program.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_next_pc.sv | 20 ++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction fields and fetch FSM states.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 8;

  localparam logic [1:0] OPC_JUMP = 2'b11;

  localparam int unsigned OPC_HI = 7;
  localparam int unsigned OPC_LO = 6;
  localparam int unsigned IMM_HI = 5;
  localparam int unsigned IMM_LO = 0;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] sext_imm(logic [IMM_HI:IMM_LO] imm);
    return {{(ADDR_W - IMM_HI - 1){imm[IMM_HI]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Sequential/jump next-pc computation for the fetch stage; arithmetic wraps mod 256.
module fetch_next_pc
  import cpu_pkg::*;
(
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               is_self_jump
);

  always_comb begin
    next_pc = pc + ADDR_W'(1);
    if (instr[OPC_HI:OPC_LO] == OPC_JUMP) begin
      next_pc = pc + ADDR_W'(1) + sext_imm(instr[IMM_HI:IMM_LO]);
    end
    // A jump onto itself is the program's halt idiom.
    is_self_jump = (next_pc == pc);
  end

endmodule

// File: rtl/fetch_unit.sv
// PC/fetch stage: drives imem, buffers one instruction for the decoder, resolves local jumps,
// honours execute-stage redirects and stops at the end of the program.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PROG_LEN = 11,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               clk,
  input  logic               clear,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               done,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  opc_q, opc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0] next_pc;
  logic              is_self_jump;
  logic              accept;
  logic              handshake;
  logic              in_prog;

  fetch_next_pc u_next_pc (
    .pc           (pc_q),
    .instr        (imem_instr),
    .next_pc      (next_pc),
    .is_self_jump (is_self_jump)
  );

  assign accept    = !valid_q || out_ready;
  assign handshake = valid_q && out_ready;
  assign in_prog   = 32'(pc_q) < PROG_LEN;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q && !out_ready;
    instr_d = instr_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q;

    if (handshake && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      RUN: begin
        if (!in_prog) begin
          state_d = DRAIN;
        end else if (accept) begin
          instr_d = imem_instr;
          opc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = next_pc;
          if (is_self_jump) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!valid_q || handshake) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d = 1'b0;
      end
      default: state_d = RUN;
    endcase

    // Redirect overrides everything, including a capture or handshake this cycle.
    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= RUN;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign done        = (state_q == DONE);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, instr} pairs are queued and checked per handshake.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       clear;
  logic [7:0] imem_addr;
  logic [7:0] imem_instr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       done;
  logic [7:0] fetch_count;

  always #5 clk = ~clk;

  fetch_unit #(
    .PROG_LEN (11),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .done        (done),
    .fetch_count (fetch_count)
  );

  logic [7:0] base_prog [11] = '{8'h49, 8'h27, 8'h39, 8'h18, 8'h07, 8'h32,
                                 8'h2D, 8'h18, 8'h4D, 8'h1E, 8'hC3};
  logic [7:0] prog [256];

  assign imem_instr = prog[imem_addr];

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    for (int i = 0; i < 11; i++) prog[i] = base_prog[i];
  endtask

  task automatic push_range(input int first, input int last);
    for (int p = first; p <= last; p++) sb.push_back({8'(p), prog[p]});
  endtask

  task automatic reset_dut();
    clear = 1'b0;
    sb.delete();
    step();
    step();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) step();
    check_eq("done_reached", 32'(done), 32'd1);
  endtask

  // Every decoder handshake must match the oldest expected fetch.
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (clear && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected", {16'h0, out_pc, out_instr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_eq("sb_fetch", {16'h0, out_pc, out_instr}, {16'h0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    load_prog();
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    clear       = 1'b0;
    #3;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_instr", 32'(out_instr), 32'd0);
    check_eq("rst_pc", 32'(out_pc), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_count", 32'(fetch_count), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);

    // Streaming run to end of program.
    reset_dut();
    push_range(0, 10);
    clear = 1'b1;
    step();
    check_eq("c1_instr", 32'(out_instr), 32'h49);
    check_eq("c1_pc", 32'(out_pc), 32'd0);
    step();
    check_eq("c2_instr", 32'(out_instr), 32'h27);
    check_eq("c2_pc", 32'(out_pc), 32'd1);
    wait_done(40);
    check_eq("a_count", 32'(fetch_count), 32'd11);
    check_eq("a_addr_past_end", 32'(imem_addr), 32'd14);
    check_eq("a_sb_empty", 32'(sb.size()), 32'd0);
    step();
    check_eq("a_done_hold", 32'(done), 32'd1);
    check_eq("a_valid_done", 32'(out_valid), 32'd0);

    // Stall, release, then redirect while stalled.
    reset_dut();
    push_range(0, 1);
    out_ready = 1'b0;
    clear = 1'b1;
    step();
    check_eq("s_instr", 32'(out_instr), 32'h49);
    check_eq("s_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("s_hold_instr", 32'(out_instr), 32'h49);
      check_eq("s_hold_addr", 32'(imem_addr), 32'd1);
    end
    out_ready = 1'b1;
    step();
    check_eq("s_rel_instr", 32'(out_instr), 32'h27);
    check_eq("s_rel_pc", 32'(out_pc), 32'd1);
    step();
    check_eq("s_count", 32'(fetch_count), 32'd2);
    check_eq("s_next_instr", 32'(out_instr), 32'h39);
    out_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'd5;
    step();
    redirect = 1'b0;
    check_eq("r_flush", 32'(out_valid), 32'd0);
    step();
    check_eq("r_instr", 32'(out_instr), 32'h32);
    check_eq("r_pc", 32'(out_pc), 32'd5);
    push_range(5, 10);
    out_ready = 1'b1;
    wait_done(40);
    check_eq("r_count", 32'(fetch_count), 32'd8);
    check_eq("r_sb_empty", 32'(sb.size()), 32'd0);

    // Redirect out of DONE.
    push_range(5, 10);
    redirect    = 1'b1;
    redirect_pc = 8'd5;
    step();
    redirect = 1'b0;
    check_eq("rd_done_drop", 32'(done), 32'd0);
    check_eq("rd_valid", 32'(out_valid), 32'd0);
    step();
    check_eq("rd_instr", 32'(out_instr), 32'h32);
    check_eq("rd_pc", 32'(out_pc), 32'd5);
    wait_done(40);
    check_eq("rd_count", 32'(fetch_count), 32'd14);
    check_eq("rd_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of a stall.
    reset_dut();
    out_ready = 1'b0;
    clear = 1'b1;
    step();
    step();
    check_eq("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    clear = 1'b0;
    #1;
    check_eq("ar_valid", 32'(out_valid), 32'd0);
    check_eq("ar_instr", 32'(out_instr), 32'd0);
    check_eq("ar_addr", 32'(imem_addr), 32'd0);
    check_eq("ar_count", 32'(fetch_count), 32'd0);
    sb.delete();
    step();
    push_range(0, 0);
    out_ready = 1'b1;
    clear = 1'b1;
    step();
    check_eq("ar_refetch_pc", 32'(out_pc), 32'd0);
    check_eq("ar_refetch_instr", 32'(out_instr), 32'h49);
    out_ready = 1'b0;
    step();

    // Self-jump halt at address 3.
    reset_dut();
    prog[3] = 8'hFF;
    push_range(0, 3);
    out_ready = 1'b1;
    clear = 1'b1;
    wait_done(40);
    check_eq("sj_count", 32'(fetch_count), 32'd4);
    check_eq("sj_addr", 32'(imem_addr), 32'd3);
    check_eq("sj_sb_empty", 32'(sb.size()), 32'd0);
    step();
    step();
    check_eq("sj_addr_frozen", 32'(imem_addr), 32'd3);
    check_eq("sj_done_hold", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
